// File: rtl/bean_mem_pkg.sv
// bean_mem_pkg: memory access mode encodings, arbiter FSM states and mode-to-width helper
package bean_mem_pkg;
  localparam logic [2:0] MODE_WORD = 3'b000;
  localparam logic [2:0] MODE_HALF_U = 3'b001;
  localparam logic [2:0] MODE_HALF_S = 3'b101;
  localparam logic [2:0] MODE_BYTE_U = 3'b010;
  localparam logic [2:0] MODE_BYTE_S = 3'b110;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  function automatic logic [2:0] mode_width(input logic [2:0] m);
    return (m == MODE_HALF_U || m == MODE_HALF_S) ? 3'd2 :
           (m == MODE_BYTE_U || m == MODE_BYTE_S) ? 3'd1 : 3'd4;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter (req in, combinational gnt out, last_grant updated when en and any req)
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_grant;
  assign gnt = &req ? (last_grant ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk)
    if (reset) last_grant <= 1'b1;
    else if (en && |req) last_grant <= gnt[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: 2-port round-robin memory sequencer (req_* in, req_ready/resp_* out, mem_* drive/capture), 1 access per 3 cycles
module mem_arbiter
  import bean_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [1:0]  req_we,
  input  logic [2:0]  req_mode0,
  input  logic [2:0]  req_mode1,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic [2:0]  mem_mode,
  input  logic [31:0] mem_rd
);
  state_t      state;
  logic [1:0]  gnt;
  logic        id, we, err, lid, lwe, lerr;
  logic [31:0] addr, wdata;
  logic [2:0]  mode;
  rr_arb2 u_arb (.clk(clk), .reset(reset), .req(req_valid), .en(state == IDLE), .gnt(gnt));
  assign req_ready = (state == IDLE && !reset) ? gnt : 2'b00;
  assign id = gnt[1];
  assign addr = id ? req_addr1 : req_addr0;
  assign wdata = id ? req_wdata1 : req_wdata0;
  assign mode = id ? req_mode1 : req_mode0;
  assign we = req_we[id];
  assign err = ({1'b0, addr} + {30'b0, mode_width(mode)}) > 33'(MEM_BYTES);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lid <= 1'b0;
      lwe <= 1'b0;
      lerr <= 1'b0;
      resp_valid <= 1'b0;
      resp_id <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      mem_a <= '0;
      mem_wd <= '0;
      mem_we <= 1'b0;
      mem_mode <= MODE_WORD;
    end else begin
      resp_valid <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          lid <= id;
          lwe <= we;
          lerr <= err;
          mem_a <= addr;
          mem_wd <= wdata;
          mem_mode <= mode;
          mem_we <= we && !err;
          state <= ISSUE;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          resp_valid <= 1'b1;
          resp_id <= lid;
          resp_err <= lerr;
          resp_rdata <= (lerr || lwe) ? 32'd0 : mem_rd;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
